// File: rtl/mvu_pkg.sv
// Shared types for the MVU APB master: transfer FSM states and the queued
// request record.
package mvu_pkg;

  localparam int APB_ADDR_WIDTH = 16;
  localparam int APB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_t;

  typedef struct packed {
    logic                      write;
    logic [APB_ADDR_WIDTH-1:0] addr;
    logic [APB_DATA_WIDTH-1:0] wdata;
  } apb_req_t;

endpackage

// File: rtl/mvu_apb_master_if.sv
// APB bus between the MVU APB master and the MVU configuration slave.
interface mvu_apb_master_if #(
  parameter int ADDR_WIDTH = mvu_pkg::APB_ADDR_WIDTH,
  parameter int DATA_WIDTH = mvu_pkg::APB_DATA_WIDTH
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/mvu_apb_req_fifo.sv
// Request FIFO for the MVU APB master. Full/empty are registered from the
// next count so req_ready never depends combinationally on the push side.
// The head entry is presented combinationally; the master captures it into
// its APB address/data registers on pop.
module mvu_apb_req_fifo
  import mvu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  apb_req_t                      push_data,
  input  logic                          pop,
  output apb_req_t                      pop_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  apb_req_t mem [FIFO_DEPTH];

  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic [CNT_W-1:0]      count_next;
  logic                  full_reg;
  logic                  empty_reg;
  logic                  push_ok;
  logic                  pop_ok;
  logic [FIFO_DEPTH-1:0] wr_en;

  assign push_ok = push && !full_reg;
  assign pop_ok  = pop && !empty_reg;

  // One-hot write enable per storage slot.
  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push_ok && (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  // Storage write; entries carry no reset since occupancy is tracked by count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (wr_en[i]) mem[i] <= push_data;
    end
  end

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointers, count and registered full/empty flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
      full_reg  <= (count_next == CNT_W'(FIFO_DEPTH));
      empty_reg <= (count_next == '0);
    end
  end

  assign pop_data = mem[rd_ptr_reg];
  assign full     = full_reg;
  assign empty    = empty_reg;
  assign count    = count_reg;

endmodule

// File: rtl/mvu_apb_master.sv
// MVU APB master: queues CSR requests and runs each as one APB SETUP/ACCESS
// transfer, returning one response per request.
// Optional build macro MVU_APB_TIMEOUT_EN bounds the ACCESS wait to TIMEOUT
// cycles and reports an error response when it expires.
module mvu_apb_master
  import mvu_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = mvu_pkg::APB_ADDR_WIDTH,
  parameter int APB_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT        = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr,
  input  logic [APB_DATA_WIDTH-1:0] req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_err,
  output logic                      busy,
  mvu_apb_master_if.master          apb
);

  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  apb_mst_state_t            state_reg;
  logic                      psel_reg;
  logic                      penable_reg;
  logic                      pwrite_reg;
  logic [APB_ADDR_WIDTH-1:0] paddr_reg;
  logic [APB_DATA_WIDTH-1:0] pwdata_reg;
  logic                      rsp_valid_reg;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata_reg;
  logic                      rsp_err_reg;

  apb_req_t                  push_data;
  apb_req_t                  head;
  logic                      push;
  logic                      pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [CNT_W-1:0]          fifo_count;

`ifdef MVU_APB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT+1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT-1);
  logic [TMO_W-1:0] tmo_cnt_reg;
`endif

  assign req_ready = !fifo_full;
  assign push      = req_valid && req_ready;

  // Pack the incoming request for the FIFO.
  always_comb begin
    push_data       = '0;
    push_data.write = req_write;
    push_data.addr  = req_addr;
    push_data.wdata = req_wdata;
  end

  mvu_apb_req_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Pop whenever the FSM is about to start a new SETUP phase.
  always_comb begin
    pop = 1'b0;
    case (state_reg)
      IDLE:    pop = !fifo_empty;
      RESP:    pop = rsp_ready && !fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  // Transfer FSM with registered APB controls and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      psel_reg      <= 1'b0;
      penable_reg   <= 1'b0;
      pwrite_reg    <= 1'b0;
      paddr_reg     <= '0;
      pwdata_reg    <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
`ifdef MVU_APB_TIMEOUT_EN
      tmo_cnt_reg   <= '0;
`endif
    end else begin
      // The popped head is held in the APB registers until the next pop,
      // which keeps paddr/pwrite/pwdata stable through SETUP and ACCESS.
      if (pop) begin
        pwrite_reg <= head.write;
        paddr_reg  <= head.addr;
        pwdata_reg <= head.wdata;
`ifdef MVU_APB_TIMEOUT_EN
        tmo_cnt_reg <= '0;
`endif
      end

      case (state_reg)
        IDLE: begin
          if (!fifo_empty) begin
            state_reg   <= SETUP;
            psel_reg    <= 1'b1;
            penable_reg <= 1'b0;
          end
        end

        SETUP: begin
          state_reg   <= ACCESS;
          penable_reg <= 1'b1;
        end

        ACCESS: begin
          if (apb.pready) begin
            state_reg     <= RESP;
            psel_reg      <= 1'b0;
            penable_reg   <= 1'b0;
            rsp_valid_reg <= 1'b1;
            rsp_rdata_reg <= pwrite_reg ? '0 : apb.prdata;
            rsp_err_reg   <= apb.pslverr;
          end
`ifdef MVU_APB_TIMEOUT_EN
          else if (tmo_cnt_reg == TMO_LAST) begin
            state_reg     <= RESP;
            psel_reg      <= 1'b0;
            penable_reg   <= 1'b0;
            rsp_valid_reg <= 1'b1;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b1;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
          end
`endif
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            if (!fifo_empty) begin
              state_reg   <= SETUP;
              psel_reg    <= 1'b1;
              penable_reg <= 1'b0;
            end else begin
              state_reg <= IDLE;
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign apb.psel    = psel_reg;
  assign apb.penable = penable_reg;
  assign apb.pwrite  = pwrite_reg;
  assign apb.paddr   = paddr_reg;
  assign apb.pwdata  = pwdata_reg;

  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;
  assign busy      = (state_reg != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_mvu_apb_master.sv
// Testbench for mvu_apb_master. A behavioural APB slave (32-word register
// window at CSR index < 0x080, error elsewhere) answers transfers; a
// request-order model predicts every response. Build with
// MVU_APB_TIMEOUT_EN to also exercise the ACCESS timeout with TIMEOUT=8.
module tb_mvu_apb_master;

  localparam int AW = 16;
  localparam int DW = 32;
`ifdef MVU_APB_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 256;
`endif
  localparam int STUCK = 1000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          busy;

  mvu_apb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

  mvu_apb_master #(
    .APB_ADDR_WIDTH(AW),
    .APB_DATA_WIDTH(DW),
    .FIFO_DEPTH    (4),
    .TIMEOUT       (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .apb       (apb)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  // Slave controls (written by the tests only while no ACCESS is running).
  int            wait_cfg = 0;   // <0: random 0..3 wait cycles per transfer
  bit            fixed_mode = 1'b0;
  logic [DW-1:0] fixed_rdata = '0;
  bit            fixed_err = 1'b0;

  // Slave state and observations.
  logic [DW-1:0] slv_mem [32];
  logic [DW-1:0] shadow  [32];
  int            acc_cnt = 0;
  int            cur_wait = 0;
  int            last_len = 0;
  int            xfer_cnt = 0;
  bit            stable_bad = 1'b0;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;
  logic [AW-1:0] log_addr  [256];
  logic [DW-1:0] log_wdata [256];

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Behavioural APB slave, evaluated on the falling edge.
  initial begin
    apb.pready  = 1'b0;
    apb.prdata  = '0;
    apb.pslverr = 1'b0;
    forever begin
      @(negedge clk);
      if (apb.psel && apb.penable) begin
        if (acc_cnt == 0) begin
          acc_addr  = apb.paddr;
          acc_wdata = apb.pwdata;
          cur_wait  = (wait_cfg < 0) ? int'($urandom_range(0, 3)) : wait_cfg;
        end else if (apb.paddr !== acc_addr || apb.pwdata !== acc_wdata) begin
          stable_bad = 1'b1;
        end
        acc_cnt++;
        if (acc_cnt > cur_wait) begin
          apb.pready = 1'b1;
          if (fixed_mode) begin
            apb.prdata  = fixed_rdata;
            apb.pslverr = fixed_err;
          end else if (apb.paddr[11:0] < 12'h080) begin
            apb.prdata  = slv_mem[apb.paddr[6:2]];
            apb.pslverr = 1'b0;
            if (apb.pwrite) slv_mem[apb.paddr[6:2]] = apb.pwdata;
          end else begin
            apb.prdata  = 32'hBAD0_BAD0;
            apb.pslverr = 1'b1;
          end
          log_addr[xfer_cnt & 255]  = apb.paddr;
          log_wdata[xfer_cnt & 255] = apb.pwdata;
          xfer_cnt++;
        end else begin
          apb.pready  = 1'b0;
          apb.prdata  = 32'h0BAD_F00D;
          apb.pslverr = 1'b0;
        end
      end else begin
        if (acc_cnt != 0) last_len = acc_cnt;
        acc_cnt     = 0;
        apb.pready  = 1'b0;
        apb.prdata  = '0;
        apb.pslverr = 1'b0;
      end
    end
  end

  // Request-order reference: responses follow acceptance order, so the
  // expected result is computed against a shadow of the slave registers.
  function automatic void model_req(input bit w, input logic [AW-1:0] a,
                                    input logic [DW-1:0] d,
                                    output logic [DW-1:0] erd, output bit eerr);
    if (a[11:0] < 12'h080) begin
      eerr = 1'b0;
      erd  = w ? '0 : shadow[a[6:2]];
      if (w) shadow[a[6:2]] = d;
    end else begin
      eerr = 1'b1;
      erd  = w ? '0 : 32'hBAD0_BAD0;
    end
  endfunction

  // Offer one request for one cycle; entered and left on a falling edge.
  task automatic push_req(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output bit accepted, output logic [DW-1:0] erd, output bit eerr);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    accepted  = req_ready;
    erd       = '0;
    eerr      = 1'b0;
    if (accepted) model_req(w, a, d, erd, eerr);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output bit ok);
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid) break;
      @(negedge clk);
    end
    ok = rsp_valid;
  endtask

  task automatic consume_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if ({apb.psel, apb.penable, apb.pwrite, rsp_valid, rsp_err, busy} !== 6'b0 ||
        apb.paddr !== '0 || apb.pwdata !== '0 || rsp_rdata !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h rsp_valid=%b rdata=%h err=%b busy=%b required all zero",
               apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata, rsp_valid, rsp_rdata, rsp_err, busy);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release req_ready=%b busy=%b rsp_valid=%b required 1/0/0", req_ready, busy, rsp_valid);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_single_write();
    bit acc, eerr, ok;
    logic [DW-1:0] erd;
    push_req(1'b1, 16'h1040, 32'hDEAD_BEEF, acc, erd, eerr);
    // Now half a cycle after acceptance edge E.
    tests_run++;
    if (acc !== 1'b1 || apb.psel !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr_accept accepted=%b psel=%b required 1/0", acc, apb.psel);
    end
    @(negedge clk);
    tests_run++;
    if (apb.psel !== 1'b1 || apb.penable !== 1'b0 || apb.pwrite !== 1'b1 || apb.paddr !== 16'h1040) begin
      tests_failed++;
      $display("FAIL wr_setup psel=%b penable=%b pwrite=%b paddr=%h required 1/0/1/1040",
               apb.psel, apb.penable, apb.pwrite, apb.paddr);
    end
    @(negedge clk);
    tests_run++;
    if (apb.psel !== 1'b1 || apb.penable !== 1'b1 || apb.paddr !== 16'h1040 ||
        apb.pwdata !== 32'hDEAD_BEEF || rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr_access psel=%b penable=%b paddr=%h pwdata=%h rsp_valid=%b required 1/1/1040/deadbeef/0",
               apb.psel, apb.penable, apb.paddr, apb.pwdata, rsp_valid);
    end
    @(negedge clk);
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== '0 || apb.psel !== 1'b0 || apb.penable !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr_resp rsp_valid=%b err=%b rdata=%h psel=%b penable=%b required 1/0/0/0/0",
               rsp_valid, rsp_err, rsp_rdata, apb.psel, apb.penable);
    end
    #1;
    tests_run++;
    if (last_len !== 1) begin
      tests_failed++;
      $display("FAIL wr_access_len got=%0d required 1", last_len);
    end
    ok = 1'b1;
    @(negedge clk);
    consume_rsp();
    tests_run++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr_done rsp_valid=%b busy=%b required 0/0", rsp_valid, busy);
    end
    $display("[TB] write 1040 <= deadbeef err=%b", eerr);
  endtask

  task automatic test_read_err();
    bit acc, eerr, ok;
    logic [DW-1:0] erd;
    fixed_mode  = 1'b1;
    fixed_rdata = 32'h0000_00A5;
    fixed_err   = 1'b1;
    push_req(1'b0, 16'h0010, '0, acc, erd, eerr);
    wait_rsp(ok);
    tests_run++;
    if (!ok || rsp_rdata !== 32'h0000_00A5 || rsp_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL rd_err valid=%b rdata=%h err=%b required 1/000000a5/1", ok, rsp_rdata, rsp_err);
    end
    consume_rsp();
    fixed_mode = 1'b0;
    $display("[TB] read 0010 -> %h err=%b", rsp_rdata, rsp_err);
  endtask

  task automatic test_back_to_back();
    bit acc, eerr;
    logic [DW-1:0] erd;
    logic [AW-1:0] ea [5];
    logic [DW-1:0] ed [5];
    int n_acc = 0;
    int base;
    int got = 0;
    int hs [5];
    base = xfer_cnt;
    for (int i = 0; i < 5; i++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      a = 16'h2000 | AW'(i * 4);
      d = $urandom;
      push_req(1'b1, a, d, acc, erd, eerr);
      if (acc) begin
        ea[n_acc] = a;
        ed[n_acc] = d;
        n_acc++;
      end
    end
    // The FSM pops the first entry on the edge after it lands, so all five
    // fit (one in flight, four buffered) and the FIFO is then full.
    tests_run++;
    if (n_acc !== 5 || req_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_fill accepted=%0d req_ready=%b required 5/0", n_acc, req_ready);
    end
    repeat (8) @(negedge clk);
    #1;
    tests_run++;
    if (xfer_cnt - base !== 1 || rsp_valid !== 1'b1 || apb.psel !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_hold transfers=%0d rsp_valid=%b psel=%b required 1/1/0", xfer_cnt - base, rsp_valid, apb.psel);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    for (int i = 0; i < 40 && got < 5; i++) begin
      if (rsp_valid) begin
        hs[got] = cyc;
        tests_run++;
        if (rsp_rdata !== '0 || rsp_err !== 1'b0) begin
          tests_failed++;
          $display("FAIL b2b_rsp%0d rdata=%h err=%b required 0/0", got, rsp_rdata, rsp_err);
        end
        $display("[TB] b2b rsp %0d addr=%h cycle=%0d", got, ea[got], cyc);
        got++;
      end
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    tests_run++;
    if (got !== 5) begin
      tests_failed++;
      $display("FAIL b2b_count got=%0d required 5", got);
    end
    for (int k = 1; k < got; k++) begin
      tests_run++;
      if (hs[k] - hs[k-1] !== 3) begin
        tests_failed++;
        $display("FAIL b2b_pitch%0d got=%0d required 3", k, hs[k] - hs[k-1]);
      end
    end
    #1;
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if (log_addr[(base + k) & 255] !== ea[k] || log_wdata[(base + k) & 255] !== ed[k]) begin
        tests_failed++;
        $display("FAIL b2b_order%0d addr=%h wdata=%h required %h/%h", k,
                 log_addr[(base + k) & 255], log_wdata[(base + k) & 255], ea[k], ed[k]);
      end
    end
  endtask

  task automatic test_wait_states();
    bit acc, eerr, ok;
    logic [DW-1:0] erd;
    int base;
    stable_bad = 1'b0;
    wait_cfg   = 10;
    base       = xfer_cnt;
    push_req(1'b1, 16'h3008, 32'h1357_9BDF, acc, erd, eerr);
    wait_rsp(ok);
    tests_run++;
    if (!ok || rsp_err !== eerr || rsp_rdata !== erd) begin
      tests_failed++;
      $display("FAIL ws_rsp valid=%b rdata=%h err=%b required 1/%h/%b", ok, rsp_rdata, rsp_err, erd, eerr);
    end
    #1;
    tests_run++;
    if (last_len !== 11 || stable_bad !== 1'b0 || xfer_cnt - base !== 1) begin
      tests_failed++;
      $display("FAIL ws_access len=%0d unstable=%b transfers=%0d required 11/0/1", last_len, stable_bad, xfer_cnt - base);
    end
    @(negedge clk);
    consume_rsp();
    wait_cfg = 0;
    $display("[TB] wait-state write 3008 len=%0d", last_len);
  endtask

`ifdef MVU_APB_TIMEOUT_EN
  task automatic test_timeout();
    bit acc, eerr_a, eerr_b, ok;
    logic [DW-1:0] erd_a, erd_b;
    wait_cfg = STUCK;
    push_req(1'b0, 16'h4004, '0, acc, erd_a, eerr_a);
    push_req(1'b0, 16'h4008, '0, acc, erd_b, eerr_b);
    wait_rsp(ok);
    tests_run++;
    if (!ok || rsp_err !== 1'b1 || rsp_rdata !== '0 || apb.psel !== 1'b0) begin
      tests_failed++;
      $display("FAIL tmo_rsp valid=%b err=%b rdata=%h psel=%b required 1/1/0/0", ok, rsp_err, rsp_rdata, apb.psel);
    end
    #1;
    tests_run++;
    if (last_len !== TMO) begin
      tests_failed++;
      $display("FAIL tmo_len got=%0d required %0d", last_len, TMO);
    end
    wait_cfg = 0;
    @(negedge clk);
    consume_rsp();
    wait_rsp(ok);
    tests_run++;
    if (!ok || rsp_err !== eerr_b || rsp_rdata !== erd_b) begin
      tests_failed++;
      $display("FAIL tmo_next valid=%b rdata=%h err=%b required 1/%h/%b", ok, rsp_rdata, rsp_err, erd_b, eerr_b);
    end
    consume_rsp();
    $display("[TB] timeout then read 4008 -> %h", erd_b);
  endtask
`endif

  task automatic test_reset_mid();
    bit acc, eerr;
    logic [DW-1:0] erd;
    bit bad = 1'b0;
    wait_cfg = STUCK;
    for (int i = 0; i < 3; i++) push_req(1'b0, AW'(16'h5000 + i * 4), '0, acc, erd, eerr);
    for (int i = 0; i < 20; i++) begin
      if (apb.psel && apb.penable) break;
      @(negedge clk);
    end
    tests_run++;
    if (!(apb.psel && apb.penable)) begin
      tests_failed++;
      $display("FAIL rst_mid_access psel=%b penable=%b required 1/1", apb.psel, apb.penable);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (apb.psel !== 1'b0 || apb.penable !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_async psel=%b penable=%b busy=%b required 0/0/0", apb.psel, apb.penable, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_cfg = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0 || apb.psel !== 1'b0) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL rst_mid_flush busy=%b req_ready=%b rsp_valid=%b psel=%b required 0/1/0/0",
               busy, req_ready, rsp_valid, apb.psel);
    end
    $display("[TB] reset during ACCESS flushed");
  endtask

  task automatic test_random();
    localparam int N = 40;
    logic [DW-1:0] q_rd [$];
    bit            q_err [$];
    int sent = 0;
    int got = 0;
    wait_cfg = -1;
    for (int t = 0; t < 3000 && got < N; t++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (rsp_valid && rsp_ready) begin
        tests_run++;
        if (q_rd.size() == 0) begin
          tests_failed++;
          $display("FAIL rnd_unexpected rdata=%h err=%b required no response", rsp_rdata, rsp_err);
        end else begin
          if (rsp_rdata !== q_rd[0] || rsp_err !== q_err[0]) begin
            tests_failed++;
            $display("FAIL rnd_rsp%0d rdata=%h err=%b required %h/%b", got, rsp_rdata, rsp_err, q_rd[0], q_err[0]);
          end
          $display("[TB] rnd rsp %0d rdata=%h err=%b", got, rsp_rdata, rsp_err);
          void'(q_rd.pop_front());
          void'(q_err.pop_front());
        end
        got++;
      end
      if (sent < N && $urandom_range(0, 1) == 1) begin
        logic [11:0] idx;
        logic [DW-1:0] erd;
        bit eerr;
        idx = ($urandom_range(0, 3) == 0) ? (12'h800 | 12'($urandom_range(0, 255)))
                                          : {5'd0, 5'($urandom), 2'b00};
        req_valid = 1'b1;
        req_write = 1'($urandom);
        req_addr  = {4'($urandom), idx};
        req_wdata = $urandom;
        if (req_ready) begin
          model_req(req_write, req_addr, req_wdata, erd, eerr);
          q_rd.push_back(erd);
          q_err.push_back(eerr);
          sent++;
        end
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    wait_cfg  = 0;
    tests_run++;
    if (sent !== N || got !== N || q_rd.size() != 0) begin
      tests_failed++;
      $display("FAIL rnd_count sent=%0d got=%0d pending=%0d required %0d/%0d/0", sent, got, q_rd.size(), N, N);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rnd_idle busy=%b rsp_valid=%b required 0/0", busy, rsp_valid);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      slv_mem[i] = 32'h5A00_0000 | 32'(i);
      shadow[i]  = 32'h5A00_0000 | 32'(i);
    end
    test_reset();
    test_single_write();
    test_read_err();
    test_back_to_back();
    test_wait_states();
`ifdef MVU_APB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
